// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the CPU datapath memory port. Byte-addressed
//   internal RAM, big-endian, req/ack handshake with WAIT wait states
//   between request capture and ack. Loads return right-aligned,
//   zero-extended data. Misaligned, out-of-range or reserved-size accesses
//   are answered with err=1, dataout=0, and no RAM write.
//
//   Handshake: req is sampled only in IDLE. The edge that samples req
//   captures wr/address/size/datain. ack is a one-cycle pulse that occurs
//   WAIT+1 cycles after the capture edge. busy is high from the cycle after
//   the capture edge through the ack cycle. req seen while busy is ignored.
//
// Parameters
//   DEPTH  RAM size in bytes (power of two, >= 4)
//   WAIT   wait cycles between capture and ack (0..15)
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-low
//   req      in   request strobe
//   wr       in   1 = store, 0 = load
//   address  in   byte address
//   size     in   00 word, 01 half, 10 byte, 11 reserved (err)
//   datain   in   store data, right-aligned
//   dataout  out  load data while ack=1, else 0
//   ack      out  one-cycle response pulse
//   err      out  error flag, valid with ack
//   busy     out  access in flight
//   rd_count/wr_count/err_count  out  (only with MEM_RESP_STATS_EN)
//
// Configuration
//   MEM_RESP_STATS_EN  adds saturating load/store/error counters.
// ----------------------------------------------------------------------------
module mem_responder #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] address,
    input  logic [1:0]  size,
    input  logic [31:0] datain,
    output logic [31:0] dataout,
    output logic        ack,
    output logic        err,
    output logic        busy
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [7:0]  err_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           wr_q, wr_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [1:0]     size_q, size_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           bad_q, bad_d;
    logic [31:0]    dataout_q, dataout_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;

    logic [7:0]     mem [DEPTH];

    logic           req_bad;
    logic [AW-1:0]  src_addr, a1, a2, a3;
    logic [1:0]     src_size;
    logic           src_wr, src_bad;
    logic [31:0]    load_data, resp_data;
    logic           mem_we;

    // Error classification of the incoming request. Aligned accesses whose
    // base is below DEPTH never run past the end of the RAM.
    always_comb begin
        req_bad = 1'b0;
        if (size == 2'b11)                           req_bad = 1'b1;
        if (size == 2'b00 && address[1:0] != 2'b00)  req_bad = 1'b1;
        if (size == 2'b01 && address[0])             req_bad = 1'b1;
        if (address >= 32'(DEPTH))                   req_bad = 1'b1;
    end

    // With WAIT=0 the response is registered on the capture edge itself, so
    // the read side looks at the live inputs while IDLE and at the captured
    // request otherwise. In RESP this is the captured address, which the
    // write port reuses.
    always_comb begin
        src_addr = (state_q == S_IDLE) ? address[AW-1:0] : addr_q;
        src_size = (state_q == S_IDLE) ? size            : size_q;
        src_wr   = (state_q == S_IDLE) ? wr              : wr_q;
        src_bad  = (state_q == S_IDLE) ? req_bad         : bad_q;
        a1 = src_addr + AW'(1);
        a2 = src_addr + AW'(2);
        a3 = src_addr + AW'(3);
        case (src_size)
            2'b00:   load_data = {mem[src_addr], mem[a1], mem[a2], mem[a3]};
            2'b01:   load_data = {16'h0000, mem[src_addr], mem[a1]};
            2'b10:   load_data = {24'h000000, mem[src_addr]};
            default: load_data = 32'h0000_0000;
        endcase
        resp_data = (src_bad || src_wr) ? 32'h0000_0000 : load_data;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        bad_d     = bad_q;
        dataout_d = 32'h0000_0000;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    addr_d  = address[AW-1:0];
                    size_d  = size;
                    wdata_d = datain;
                    bad_d   = req_bad;
                    cnt_d   = 4'(WAIT);
                    if (WAIT == 0) begin
                        state_d   = S_RESP;
                        ack_d     = 1'b1;
                        err_d     = req_bad;
                        dataout_d = resp_data;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d   = S_RESP;
                    ack_d     = 1'b1;
                    err_d     = bad_q;
                    dataout_d = resp_data;
                end
            end
            S_RESP: begin
                // The store commits on the edge that ends the ack cycle;
                // req is not looked at here.
                mem_we  = wr_q && !bad_q;
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            size_q    <= 2'b00;
            wdata_q   <= 32'h0000_0000;
            bad_q     <= 1'b0;
            dataout_q <= 32'h0000_0000;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            bad_q     <= bad_d;
            dataout_q <= dataout_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // RAM is not reset. mem_we derives from the reset state register, so a
    // reset that lands mid-access suppresses the write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            case (size_q)
                2'b00: begin
                    mem[src_addr] <= wdata_q[31:24];
                    mem[a1]       <= wdata_q[23:16];
                    mem[a2]       <= wdata_q[15:8];
                    mem[a3]       <= wdata_q[7:0];
                end
                2'b01: begin
                    mem[src_addr] <= wdata_q[15:8];
                    mem[a1]       <= wdata_q[7:0];
                end
                2'b10: begin
                    mem[src_addr] <= wdata_q[7:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign dataout = dataout_q;
    assign ack     = ack_q;
    assign err     = err_q;
    assign busy    = busy_q;

`ifdef MEM_RESP_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic [7:0]  err_count_q, err_count_d;

    // Counters update on the edge that ends the ack cycle.
    always_comb begin
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        err_count_d = err_count_q;
        if (state_q == S_RESP) begin
            if (bad_q) begin
                if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            end else if (wr_q) begin
                if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
            end else begin
                if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count_q  <= 16'h0000;
            wr_count_q  <= 16'h0000;
            err_count_q <= 8'h00;
        end else begin
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
//   Directed bench for mem_responder. u_a runs with WAIT=2, u_b with WAIT=0.
//   Both share clock and reset. Inputs are driven on the falling edge and
//   outputs are sampled on the falling edge, away from the active edge.
// ----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int WAIT_A = 2;

    logic        clk;
    logic        rst;

    logic        req_a, wr_a, ack_a, err_a, busy_a;
    logic [31:0] addr_a, din_a, dout_a;
    logic [1:0]  size_a;

    logic        req_b, wr_b, ack_b, err_b, busy_b;
    logic [31:0] addr_b, din_b, dout_b;
    logic [1:0]  size_b;

`ifdef MEM_RESP_STATS_EN
    logic [15:0] rd_cnt_a, wr_cnt_a, rd_cnt_b, wr_cnt_b;
    logic [7:0]  err_cnt_a, err_cnt_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mem_responder #(.DEPTH(256), .WAIT(WAIT_A)) u_a (
        .clk(clk), .rst(rst), .req(req_a), .wr(wr_a), .address(addr_a),
        .size(size_a), .datain(din_a), .dataout(dout_a), .ack(ack_a),
        .err(err_a), .busy(busy_a)
`ifdef MEM_RESP_STATS_EN
        , .rd_count(rd_cnt_a), .wr_count(wr_cnt_a), .err_count(err_cnt_a)
`endif
    );

    mem_responder #(.DEPTH(256), .WAIT(0)) u_b (
        .clk(clk), .rst(rst), .req(req_b), .wr(wr_b), .address(addr_b),
        .size(size_b), .datain(din_b), .dataout(dout_b), .ack(ack_b),
        .err(err_b), .busy(busy_b)
`ifdef MEM_RESP_STATS_EN
        , .rd_count(rd_cnt_b), .wr_count(wr_cnt_b), .err_count(err_cnt_b)
`endif
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access on u_a (sel_b=0) or u_b (sel_b=1). Entered and left
    // on a falling edge with the selected DUT idle.
    task automatic access(input bit sel_b, input logic w, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] d,
                          input logic [31:0] exp_dout, input logic exp_err,
                          input string tag);
        int nw;
        nw = sel_b ? 0 : WAIT_A;
        if (sel_b) begin
            req_b = 1'b1; wr_b = w; addr_b = a; size_b = sz; din_b = d;
        end else begin
            req_a = 1'b1; wr_a = w; addr_a = a; size_a = sz; din_a = d;
        end
        @(posedge clk);
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
        for (int i = 0; i < nw; i++) begin
            check({tag, "_wait_ack"},  sel_b ? ack_b : ack_a, 32'd0);
            check({tag, "_wait_busy"}, sel_b ? busy_b : busy_a, 32'd1);
            @(negedge clk);
        end
        check({tag, "_ack"},  sel_b ? ack_b : ack_a, 32'd1);
        check({tag, "_busy"}, sel_b ? busy_b : busy_a, 32'd1);
        check({tag, "_err"},  sel_b ? err_b : err_a, {31'd0, exp_err});
        check({tag, "_dout"}, sel_b ? dout_b : dout_a, exp_dout);
        @(negedge clk);
        check({tag, "_ack_off"},  sel_b ? ack_b : ack_a, 32'd0);
        check({tag, "_busy_off"}, sel_b ? busy_b : busy_a, 32'd0);
        check({tag, "_dout_off"}, sel_b ? dout_b : dout_a, 32'd0);
    endtask

    initial begin
        int acks;
        rst = 1'b0;
        req_a = 1'b0; wr_a = 1'b0; addr_a = '0; size_a = 2'b00; din_a = '0;
        req_b = 1'b0; wr_b = 1'b0; addr_b = '0; size_b = 2'b00; din_b = '0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ack_a",  ack_a,  32'd0);
        check("rst_err_a",  err_a,  32'd0);
        check("rst_busy_a", busy_a, 32'd0);
        check("rst_dout_a", dout_a, 32'd0);
        check("rst_ack_b",  ack_b,  32'd0);
        check("rst_busy_b", busy_b, 32'd0);
`ifdef MEM_RESP_STATS_EN
        check("rst_rd_cnt",  rd_cnt_a,  32'd0);
        check("rst_wr_cnt",  wr_cnt_a,  32'd0);
        check("rst_err_cnt", err_cnt_a, 32'd0);
`endif
        rst = 1'b1;
        @(negedge clk);

        // word store and load, WAIT=2 latency
        access(0, 1, 32'h10, 2'b00, 32'hDEADBEEF, 32'h0, 0, "st_w10");
        access(0, 0, 32'h10, 2'b00, 32'h0, 32'hDEADBEEF, 0, "ld_w10");

        // byte merge, half and byte loads
        access(0, 1, 32'h11, 2'b10, 32'h123456AA, 32'h0, 0, "st_b11");
        access(0, 0, 32'h10, 2'b00, 32'h0, 32'hDEAABEEF, 0, "ld_w10_b");
        access(0, 0, 32'h12, 2'b01, 32'h0, 32'h0000BEEF, 0, "ld_h12");
        access(0, 0, 32'h11, 2'b10, 32'h0, 32'h000000AA, 0, "ld_b11");

        // error cases, then readback unchanged
        access(0, 0, 32'h0E,  2'b00, 32'h0, 32'h0, 1, "ld_w0e_mis");
        access(0, 1, 32'h100, 2'b00, 32'h11223344, 32'h0, 1, "st_w100_oor");
        access(0, 1, 32'h13,  2'b01, 32'h00005555, 32'h0, 1, "st_h13_mis");
        access(0, 1, 32'h10,  2'b11, 32'h99999999, 32'h0, 1, "st_rsv");
        access(0, 0, 32'h10,  2'b11, 32'h0, 32'h0, 1, "ld_rsv");
        access(0, 0, 32'h100, 2'b10, 32'h0, 32'h0, 1, "ld_b100_oor");
        access(0, 0, 32'h10,  2'b00, 32'h0, 32'hDEAABEEF, 0, "ld_w10_c");

        // top of RAM
        access(0, 1, 32'hFC, 2'b00, 32'hCAFEF00D, 32'h0, 0, "st_wfc");
        access(0, 0, 32'hFF, 2'b10, 32'h0, 32'h0000000D, 0, "ld_bff");
        access(0, 0, 32'hFE, 2'b01, 32'h0, 32'h0000F00D, 0, "ld_hfe");
        access(0, 0, 32'hFC, 2'b00, 32'h0, 32'hCAFEF00D, 0, "ld_wfc");

        // half store uses only datain[15:0]
        access(0, 1, 32'h12, 2'b01, 32'hFFFF9876, 32'h0, 0, "st_h12");
        access(0, 0, 32'h10, 2'b00, 32'h0, 32'hDEAA9876, 0, "ld_w10_d");

        // reset during WAIT of a store drops it
        access(0, 1, 32'h20, 2'b00, 32'hA5A5A5A5, 32'h0, 0, "st_w20");
        req_a = 1'b1; wr_a = 1'b1; addr_a = 32'h20; size_a = 2'b00; din_a = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_a = 1'b0;
        check("mid_busy_pre", busy_a, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_busy_rst", busy_a, 32'd0);
        check("mid_ack_rst",  ack_a,  32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_ack_hold", ack_a, 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_ack_after", ack_a, 32'd0);
        end
        access(0, 0, 32'h20, 2'b00, 32'h0, 32'hA5A5A5A5, 0, "ld_w20");

        // WAIT=0: clear bytes 0..11, then hold req for 10 cycles
        access(1, 1, 32'h0, 2'b00, 32'h0, 32'h0, 0, "b_clr0");
        access(1, 1, 32'h4, 2'b00, 32'h0, 32'h0, 0, "b_clr4");
        access(1, 1, 32'h8, 2'b00, 32'h0, 32'h0, 0, "b_clr8");
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            check("held_ack",  ack_b,  32'(k % 2));
            check("held_busy", busy_b, 32'(k % 2));
            if (ack_b === 1'b1) acks++;
            req_b = 1'b1; wr_b = 1'b1; size_b = 2'b10;
            addr_b = 32'(k); din_b = 32'h80 + 32'(k);
            @(negedge clk);
        end
        req_b = 1'b0;
        check("held_ack_end",  ack_b,  32'd0);
        check("held_busy_end", busy_b, 32'd0);
        check("held_ack_count", 32'(acks), 32'd5);
        @(negedge clk);
        access(1, 0, 32'h0, 2'b00, 32'h0, 32'h80008200, 0, "b_ld0");
        access(1, 0, 32'h4, 2'b00, 32'h0, 32'h84008600, 0, "b_ld4");
        access(1, 0, 32'h8, 2'b00, 32'h0, 32'h88000000, 0, "b_ld8");

`ifdef MEM_RESP_STATS_EN
        rst = 1'b0;
        @(negedge clk);
        check("st_rd_clr",  rd_cnt_a,  32'd0);
        check("st_wr_clr",  wr_cnt_a,  32'd0);
        check("st_err_clr", err_cnt_a, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        access(0, 0, 32'h20, 2'b00, 32'h0, 32'hA5A5A5A5, 0, "s_ld1");
        access(0, 0, 32'h20, 2'b00, 32'h0, 32'hA5A5A5A5, 0, "s_ld2");
        access(0, 1, 32'h30, 2'b10, 32'h11, 32'h0, 0, "s_st1");
        access(0, 0, 32'h21, 2'b00, 32'h0, 32'h0, 1, "s_err");
        access(0, 1, 32'h31, 2'b10, 32'h22, 32'h0, 0, "s_st2");
        access(0, 0, 32'h30, 2'b01, 32'h0, 32'h00001122, 0, "s_ld3");
        check("st_rd_cnt",  rd_cnt_a,  32'd3);
        check("st_wr_cnt",  wr_cnt_a,  32'd2);
        check("st_err_cnt", err_cnt_a, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("st_rd_rst",  rd_cnt_a,  32'd0);
        check("st_wr_rst",  wr_cnt_a,  32'd0);
        check("st_err_rst", err_cnt_a, 32'd0);
        rst = 1'b1;
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
